// File: rtl/buffer_fill_ctrl_pkg.sv
// rtl/buffer_fill_ctrl_pkg.sv - shared states, buffer modes and default geometry
package buffer_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_RX = 1'b0;
    localparam logic MODE_TX = 1'b1;

    localparam int IMG_W_DEF    = 150;
    localparam int IMG_H_DEF    = 150;
    localparam int PIX_W_DEF    = 8;
    localparam int CNT_W_DEF    = 15;
    localparam int WD_SLACK_DEF = 16;

endpackage

// File: rtl/buffer_fill_ctrl_if.sv
// rtl/buffer_fill_ctrl_if.sv - pixel stream and frame buffer signal bundle
interface buffer_fill_ctrl_if
    import buffer_fill_ctrl_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;
    logic             buf_enb;
    logic             buf_mode;
    logic             buf_bit;
    logic [CNT_W-1:0] buf_cnt;
    logic             buf_complete;

    modport master (
        input  pix_in, pix_valid, buf_complete,
        output pix_ready, buf_enb, buf_mode, buf_bit, buf_cnt
    );

    modport slave (
        output pix_in, pix_valid, buf_complete,
        input  pix_ready, buf_enb, buf_mode, buf_bit, buf_cnt
    );
endinterface

// File: rtl/buffer_fill_ctrl_pix_threshold.sv
// rtl/buffer_fill_ctrl_pix_threshold.sv - registered pixel threshold with write strobe
module buffer_fill_ctrl_pix_threshold #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic [PIX_W-1:0] pix,
    input  logic [PIX_W-1:0] thr,
    output logic             bit_out,
    output logic             valid
);
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_out <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= accept;
            if (accept) begin
                bit_out <= (pix >= thr);
            end
        end
    end
endmodule

// File: rtl/buffer_fill_ctrl.sv
// rtl/buffer_fill_ctrl.sv - fills the 1-bit frame buffer, then drains it under a watchdog
module buffer_fill_ctrl
    import buffer_fill_ctrl_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int WD_SLACK = WD_SLACK_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PIX_W-1:0]    thr,
    buffer_fill_ctrl_if.master  bus,
    output logic                busy,
    output logic                frame_done,
    output logic                wd_err
);
    localparam int                N        = IMG_W * IMG_H;
    localparam int                WD_W     = $clog2(N + WD_SLACK);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(N + WD_SLACK - 1);

    state_t           state_q, state_d;
    logic [PIX_W-1:0] thr_q;
    logic [CNT_W-1:0] pix_cnt_q;
    logic [CNT_W-1:0] buf_cnt_q;
    logic [WD_W-1:0]  wd_q;
    logic             mode_q;
    logic             wd_err_q;
    logic             accept;
    logic             start_ok;
    logic             timeout;
    logic             bit_q;
    logic             bit_valid;

    buffer_fill_ctrl_pix_threshold #(.PIX_W(PIX_W)) u_thr (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .pix     (bus.pix_in),
        .thr     (thr_q),
        .bit_out (bit_q),
        .valid   (bit_valid)
    );

    // In DRAIN the final pixel write rides on bit_valid, then send mode keeps enable high.
    assign bus.buf_enb   = bit_valid | (mode_q == MODE_TX);
    assign bus.buf_mode  = mode_q;
    assign bus.buf_bit   = bit_q;
    assign bus.buf_cnt   = buf_cnt_q;
    assign bus.pix_ready = (state_q == FILL);
    assign wd_err        = wd_err_q;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        start_ok   = 1'b0;
        timeout    = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = FILL;
                end
            end
            FILL: begin
                busy   = 1'b1;
                accept = bus.pix_valid;
                if (accept && pix_cnt_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (bus.buf_complete) begin
                    state_d = DONE;
                end else if (wd_q == WD_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            thr_q     <= '0;
            pix_cnt_q <= '0;
            buf_cnt_q <= '0;
            wd_q      <= '0;
            mode_q    <= MODE_RX;
            wd_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                thr_q     <= thr;
                pix_cnt_q <= '0;
                wd_q      <= '0;
                wd_err_q  <= 1'b0;
            end
            if (accept) begin
                buf_cnt_q <= pix_cnt_q;
                if (pix_cnt_q != LAST_IDX) begin
                    pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                end
            end
            if (state_q == DRAIN) begin
                wd_q <= wd_q + WD_W'(1);
            end
            mode_q <= (state_q == DRAIN && state_d == DRAIN) ? MODE_TX : MODE_RX;
            if (timeout) begin
                wd_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// tb/tb_buffer_fill_ctrl.sv - randomized self-checking bench for buffer_fill_ctrl
module tb_buffer_fill_ctrl;
    import buffer_fill_ctrl_pkg::*;

    localparam int N      = IMG_W_DEF * IMG_H_DEF;
    localparam int WD_LIM = N + WD_SLACK_DEF;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] thr;
    logic       busy;
    logic       frame_done;
    logic       wd_err;

    buffer_fill_ctrl_if bif ();

    buffer_fill_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .thr        (thr),
        .bus        (bif),
        .busy       (busy),
        .frame_done (frame_done),
        .wd_err     (wd_err)
    );

    always #5 clk = ~clk;

    int   n_pass  = 0;
    int   n_total = 0;
    int   m_cnt;
    logic m_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ready"}, bif.pix_ready, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_enb"},   bif.buf_enb, 0);
        chk({tag, "_mode"},  bif.buf_mode, 0);
        chk({tag, "_done"},  frame_done, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        check_idle("rst");
        chk("rst_bit",   bif.buf_bit, 0);
        chk("rst_cnt",   bif.buf_cnt, 0);
        chk("rst_wderr", wd_err, 0);
        reset = 1'b0;
        bif.pix_valid = 1'b0;
        m_cnt = 0;
        m_bit = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] t);
        start = 1'b1;
        thr   = t;
        step();
        start = 1'b0;
        chk("start_busy",  busy, 1);
        chk("start_ready", bif.pix_ready, 1);
        chk("start_wderr", wd_err, 0);
        chk("start_enb",   bif.buf_enb, 0);
    endtask

    // val_mode: 0 = index mod 256, 1 = uniform random, 2 = random with frequent 255
    task automatic run_fill(input logic [7:0] t, input int valid_pct, input int val_mode,
                            input int stop_at, input int pulse_at);
        int   idx = 0;
        bit   pulsed = 0;
        logic v;
        logic [7:0] val;
        while (idx < stop_at) begin
            v = ($urandom_range(99) < valid_pct);
            case (val_mode)
                0:       val = 8'(idx % 256);
                1:       val = 8'($urandom_range(255));
                default: val = ($urandom_range(3) == 0) ? 8'd255 : 8'($urandom_range(255));
            endcase
            bif.pix_valid = v;
            bif.pix_in    = val;
            if (idx == pulse_at && !pulsed) begin
                start  = 1'b1;
                thr    = ~t;
                pulsed = 1;
            end
            chk("fill_ready", bif.pix_ready, 1);
            step();
            start = 1'b0;
            if (v) begin
                m_cnt = idx;
                m_bit = (val >= t);
                idx++;
            end
            chk("fill_enb", bif.buf_enb, 32'(v));
            chk("fill_cnt", bif.buf_cnt, m_cnt);
            chk("fill_bit", bif.buf_bit, 32'(m_bit));
            if (v && idx == N) begin
                chk("last_ready_drop", bif.pix_ready, 0);
                chk("last_mode_rx",    bif.buf_mode, 0);
            end
        end
        bif.pix_valid = 1'b0;
    endtask

    task automatic run_drain(input int complete_at);
        for (int d = 1; d <= WD_LIM; d++) begin
            chk("drain_busy",  busy, 1);
            chk("drain_ready", bif.pix_ready, 0);
            chk("drain_enb",   bif.buf_enb, 1);
            chk("drain_mode",  bif.buf_mode, 32'(d >= 2));
            chk("drain_done",  frame_done, 0);
            chk("drain_wderr", wd_err, 0);
            chk("drain_cnt",   bif.buf_cnt, N - 1);
            bif.buf_complete = (d == complete_at);
            step();
            bif.buf_complete = 1'b0;
            if (d == complete_at) begin
                chk("done_pulse", frame_done, 1);
                chk("done_busy",  busy, 0);
                chk("done_mode",  bif.buf_mode, 0);
                chk("done_enb",   bif.buf_enb, 0);
                chk("done_wderr", wd_err, 0);
                step();
                chk("done_once",  frame_done, 0);
                check_idle("post_done");
                return;
            end
        end
        chk("wd_err_set", wd_err, 1);
        check_idle("wd");
    endtask

    initial begin
        logic [7:0] t;
        reset = 1'b1;
        start = 1'b0;
        thr   = 8'd0;
        bif.pix_valid    = 1'b0;
        bif.pix_in       = '0;
        bif.buf_complete = 1'b0;
        m_cnt = 0;
        m_bit = 1'b0;
        step();
        do_reset();

        bif.pix_valid = 1'b1;
        step();
        check_idle("idle_valid");
        bif.pix_valid = 1'b0;

        // Full frame, ramp pixels, stray start at pixel 500, buffer completes 100 cycles in
        do_start(8'd128);
        run_fill(8'd128, 100, 0, N, 500);
        run_drain(100);

        // Random threshold and gappy valid, buffer never completes
        t = 8'($urandom_range(255));
        do_start(t);
        run_fill(t, 88, 1, N, -1);
        run_drain(0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wd_err_sticky", wd_err, 1);
            check_idle("wd_idle");
        end

        // Reset mid-frame at pixel 10000
        do_start(8'd128);
        run_fill(8'd128, 100, 1, 10000, -1);
        bif.pix_valid = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("post_rst");
        end

        do_start(8'd0);
        run_fill(8'd0, 90, 1, 2000, -1);
        do_reset();

        do_start(8'd255);
        run_fill(8'd255, 90, 2, 2000, -1);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
